// File: rtl/booth_r4_mult.sv
// booth_r4_mult: sequential radix-4 Booth multiplier, signed/unsigned, ready/start/valid handshake; ports clk_i, reset_i, start_i, signed_i, multiplicand_i, multiplier_i -> ready_o, busy_o, product_o, valid_o; define BOOTH_R4_ABORT_EN to add abort_i
module booth_r4_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
`ifdef BOOTH_R4_ABORT_EN
  input  logic               abort_i,
`endif
  output logic               ready_o,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic               valid_o
);
  localparam int N = WIDTH/2+1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [2*WIDTH-1:0] a_sh, acc, pp, acc_nxt;
  logic [WIDTH+2:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic [2:0] d;
  logic abort, accept, last;
`ifdef BOOTH_R4_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  assign ready_o = state != CALC;
  assign busy_o = state == CALC;
  assign valid_o = state == DONE;
  assign accept = ready_o && start_i;
  assign last = cnt == CNT_W'(N-1);
  assign d = b_sh[2:0];
  // a_sh is A extended to full product width and pre-shifted by 2i, so the digit weight is applied in place
  assign pp = (d == 3'b001 || d == 3'b010) ? a_sh :
              d == 3'b011 ? a_sh << 1 :
              d == 3'b100 ? -(a_sh << 1) :
              (d == 3'b101 || d == 3'b110) ? -a_sh : '0;
  assign acc_nxt = acc + pp;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? CALC : state == CALC ? (abort ? IDLE : last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      cnt <= '0;
      product_o <= '0;
    end else if (accept) begin
      a_sh <= {{WIDTH{signed_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
      // two extension bits above B plus the implicit B[-1]=0 below it
      b_sh <= {{2{signed_i & multiplier_i[WIDTH-1]}}, multiplier_i, 1'b0};
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last && !abort) product_o <= acc_nxt;
    end
endmodule

// File: tb/tb_booth_r4_mult.sv
// tb_booth_r4_mult: directed self-checking bench for booth_r4_mult (8-bit and 16-bit instances)
module tb_booth_r4_mult;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, sg = 1'b0, abort = 1'b0;
  logic [7:0] mc = '0, mp = '0;
  logic ready, busy, valid;
  logic [15:0] product;
  logic start16 = 1'b0, abort16 = 1'b0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic ready16, busy16, valid16;
  logic [31:0] product16;
  int checks = 0, errors = 0, lat;
  always #5 clk = ~clk;
  booth_r4_mult #(.WIDTH(8)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .signed_i(sg),
    .multiplicand_i(mc), .multiplier_i(mp),
`ifdef BOOTH_R4_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(ready), .busy_o(busy), .product_o(product), .valid_o(valid));
  booth_r4_mult #(.WIDTH(16)) dut16 (
    .clk_i(clk), .reset_i(rst), .start_i(start16), .signed_i(1'b1),
    .multiplicand_i(mc16), .multiplier_i(mp16),
`ifdef BOOTH_R4_ABORT_EN
    .abort_i(abort16),
`endif
    .ready_o(ready16), .busy_o(busy16), .product_o(product16), .valid_o(valid16));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    start = 1'b1;
    mc = a;
    mp = b;
    sg = s;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_valid(output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        l = i;
        break;
      end
    end
  endtask
  task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    launch(a, b, s);
    wait_valid(lat);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_prod"}, product, exp);
  endtask
  initial begin
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mul("s_m128x3", 8'h80, 8'h03, 1'b1, 16'hFE80);
    @(negedge clk);
    check("pulse_one", valid, 0);
    check("hold_prod", product, 16'hFE80);
    check("idle_ready", ready, 1);
    mul("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    mul("s_ffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    mul("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
    @(negedge clk);
    mul("s_2x3", 8'h02, 8'h03, 1'b1, 16'h0006);
    launch(8'h07, 8'hFA, 1'b1);
    check("b2b_busy", busy, 1);
    wait_valid(lat);
    check("b2b_gap", lat + 1, 6);
    check("b2b_prod", product, 16'hFFD6);
    @(negedge clk);
    launch(8'd10, 8'd10, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        start = 1'b1;
        mc = 8'd5;
        mp = 8'd5;
      end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      check("calc_busy", busy, 1);
      check("calc_ready", ready, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("ign_valid", valid, 1);
    check("ign_prod", product, 100);
    @(negedge clk);
    launch(8'd9, 8'd9, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mul("zero", 8'h00, 8'h00, 1'b0, 16'h0000);
    @(negedge clk);
`ifdef BOOTH_R4_ABORT_EN
    launch(8'd10, 8'd10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    wait_valid(lat);
    check("abort_novalid", lat, 0);
    check("abort_prod", product, 0);
    launch(8'd3, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_valid", valid, 0);
    check("abort_last_prod", product, 0);
    @(negedge clk);
`endif
    start16 = 1'b1;
    mc16 = 16'h8000;
    mp16 = 16'h7FFF;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (valid16) begin
        lat = i;
        break;
      end
    end
    check("w16_lat", lat, 9);
    check("w16_prod", product16, 32'hC0008000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
